// File: rtl/dtw_feeder.sv
// Feeds one query plus a prefetched reference stream into the DTW core, then drains it and returns min cost/position.
// Latency start->first core step 3 cycles; stalls the core when query or reference is short; result held until res_ready. Option: DTW_FEEDER_STALL_CNT_EN.

module dtw_feeder_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdat_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdat_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= ptr_inc(wptr_q);
      if (pop_i)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdat_i;
  end

  assign rdat_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

module dtw_feeder #(
  parameter int               WIDTH    = 16,
  parameter int               SQG_SIZE = 250,
  parameter int               REF_AW   = 20,
  parameter logic [WIDTH-1:0] PAD      = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ref_len,
  input  logic [WIDTH-1:0]  sqg_data,
  input  logic              sqg_valid,
  output logic              sqg_ready,
  output logic              ref_rd_en,
  output logic [REF_AW-1:0] ref_addr,
  input  logic [WIDTH-1:0]  ref_rdata,
  output logic              core_rst,
  output logic              core_running,
  output logic [WIDTH-1:0]  core_squiggle,
  output logic [WIDTH-1:0]  core_rword,
  output logic [31:0]       core_ref_len,
  input  logic              core_done,
  input  logic [WIDTH-1:0]  core_minval,
  input  logic [31:0]       core_position,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_minval,
  output logic [31:0]       res_position,
  output logic [31:0]       stall_cycles
);
  localparam int QW = $clog2(SQG_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_RESULT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      ref_len_q;
  logic [QW-1:0]    qcnt_q;
  logic [31:0]      fptr_q;
  logic [31:0]      pcnt_q;
  logic             rd_pend_q;
  logic             drain_q;
  logic [WIDTH-1:0] res_minval_q;
  logic [31:0]      res_position_q;

  logic             job_go, in_run, q_need, ref_pad, word_avail;
  logic             run_step, consume, sqg_fire, rd_issue;
  logic             fifo_pop, fifo_push, fifo_nonempty;
  logic [1:0]       fifo_cnt;
  logic [2:0]       inflight;
  logic [WIDTH-1:0] fifo_rdat, head_word;

  dtw_feeder_fifo #(.W(WIDTH), .DEPTH(2)) u_pref (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (job_go),
    .push_i  (fifo_push),
    .wdat_i  (ref_rdata),
    .pop_i   (fifo_pop),
    .rdat_o  (fifo_rdat),
    .count_o (fifo_cnt)
  );

  assign job_go        = (state_q == S_IDLE) & start;
  assign in_run        = (state_q == S_RUN);
  assign q_need        = qcnt_q < QW'(SQG_SIZE);
  assign ref_pad       = (pcnt_q == ref_len_q);
  assign fifo_nonempty = (fifo_cnt != 2'd0);
  // A read returning this cycle can be consumed directly when the FIFO is empty.
  assign word_avail    = ref_pad | fifo_nonempty | rd_pend_q;
  assign head_word     = fifo_nonempty ? fifo_rdat : ref_rdata;

  // The done cycle is a hold, not a step: the core has already finished.
  assign run_step  = in_run & word_avail & ~core_done & (~q_need | sqg_valid);
  assign sqg_ready = in_run & q_need & word_avail & ~core_done;
  assign sqg_fire  = sqg_valid & sqg_ready;
  assign consume   = run_step & ~ref_pad;
  assign fifo_pop  = consume & fifo_nonempty;
  assign fifo_push = rd_pend_q & ~(consume & ~fifo_nonempty);

  // Credit check counts the word leaving this cycle so prefetch sustains one per cycle.
  assign inflight = 3'(fifo_cnt) + 3'(rd_pend_q) - 3'(consume);
  assign rd_issue = in_run & (fptr_q < ref_len_q) & (inflight < 3'd2);

  assign ref_rd_en     = rd_issue;
  assign ref_addr      = fptr_q[REF_AW-1:0];
  assign core_rst      = rst | (state_q == S_CLR);
  assign core_running  = run_step | (state_q == S_DRAIN);
  assign core_squiggle = (in_run & q_need) ? sqg_data : '0;
  assign core_rword    = (in_run & ~ref_pad) ? head_word : PAD;
  assign core_ref_len  = ref_len_q;
  assign busy          = (state_q != S_IDLE);
  assign res_valid     = (state_q == S_RESULT);
  assign res_minval    = res_minval_q;
  assign res_position  = res_position_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLR;
      S_CLR:    state_d = (ref_len_q == 32'd0) ? S_RESULT : S_RUN;
      S_RUN:    if (core_done) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q) state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ref_len_q      <= '0;
      qcnt_q         <= '0;
      fptr_q         <= '0;
      pcnt_q         <= '0;
      rd_pend_q      <= 1'b0;
      drain_q        <= 1'b0;
      res_minval_q   <= '1;
      res_position_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_issue;
      drain_q   <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
      if (job_go) begin
        ref_len_q <= ref_len;
        qcnt_q    <= '0;
        fptr_q    <= '0;
        pcnt_q    <= '0;
      end else begin
        if (rd_issue) fptr_q <= fptr_q + 32'd1;
        if (consume)  pcnt_q <= pcnt_q + 32'd1;
        if (sqg_fire) qcnt_q <= qcnt_q + QW'(1);
      end
      if (state_q == S_CLR && ref_len_q == 32'd0) begin
        res_minval_q   <= '1;
        res_position_q <= '0;
      end else if (state_q == S_DRAIN && drain_q) begin
        res_minval_q   <= core_minval;
        res_position_q <= core_position;
      end
    end
  end

`ifdef DTW_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_CLR) begin
      stall_q <= '0;
    end else if (in_run && !run_step && !core_done && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule
